// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings, FSM states
// and op-decode helpers.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } mdu_state_e;

  function automatic logic is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_neg_cond.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix-up.
module mdu_neg_cond #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] data_i,
  input  logic             neg_i,
  output logic [Width-1:0] data_o
);

  assign data_o = neg_i ? (~data_i + Width'(1)) : data_i;

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle shift-add multiplier / restoring divider producing HI/LO for MULT, MULTU, DIV, DIVU.
// Optional build macro MDU_EARLY_TERM_EN: multiplies exit RUN once the remaining multiplier bits are zero.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned W2 = 2 * WIDTH;

  mdu_state_e state_q, state_d;

  logic             op_div_q;
  logic             quo_neg_q;
  logic             rem_neg_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] lo_q;
  logic [CNT_W-1:0] cnt_q;
  logic             div_zero_q;
  logic [WIDTH-1:0] hi_res_q;
  logic [WIDTH-1:0] lo_res_q;

  logic             accept;
  logic             op_is_div;
  logic             op_is_signed;
  logic             a_neg;
  logic             b_neg;
  logic             b_zero;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic             div_ge;
  logic             run_last;
  logic             mul_done_early;
  logic [W2-1:0]    prod_raw;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // Operand decode and magnitude extraction
  assign accept       = (state_q == S_IDLE) && start;
  assign op_is_div    = is_div(op);
  assign op_is_signed = is_signed(op);
  assign a_neg        = op_is_signed & a_in[WIDTH-1];
  assign b_neg        = op_is_signed & b_in[WIDTH-1];
  assign b_zero       = (b_in == '0);

  mdu_neg_cond #(.Width(WIDTH)) u_abs_a (
    .data_i (a_in),
    .neg_i  (a_neg),
    .data_o (a_abs)
  );

  mdu_neg_cond #(.Width(WIDTH)) u_abs_b (
    .data_i (b_in),
    .neg_i  (b_neg),
    .data_o (b_abs)
  );

  // One iteration of each datapath; rem_q doubles as the product high half when multiplying
  assign mul_sum   = {1'b0, rem_q} + ({1'b0, a_q} & {(WIDTH + 1){b_q[0]}});
  assign div_trial = {rem_q, lo_q[WIDTH-1]};
  assign div_ge    = (div_trial >= {1'b0, b_q});
  assign run_last  = (cnt_q == CNT_W'(1));

`ifdef MDU_EARLY_TERM_EN
  // b_q shifts right each multiply step, so its upper bits are the unprocessed multiplier bits.
  // On an early exit cnt_q holds the shifts still owed, applied here before the sign fix.
  assign mul_done_early = ~op_div_q & (b_q[WIDTH-1:1] == '0);
  assign prod_raw       = {rem_q, lo_q} >> cnt_q;
`else
  assign mul_done_early = 1'b0;
  assign prod_raw       = {rem_q, lo_q};
`endif

  mdu_neg_cond #(.Width(W2)) u_fix_prod (
    .data_i (prod_raw),
    .neg_i  (quo_neg_q),
    .data_o (prod_fix)
  );

  mdu_neg_cond #(.Width(WIDTH)) u_fix_quo (
    .data_i (lo_q),
    .neg_i  (quo_neg_q),
    .data_o (quo_fix)
  );

  mdu_neg_cond #(.Width(WIDTH)) u_fix_rem (
    .data_i (rem_q),
    .neg_i  (rem_neg_q),
    .data_o (rem_fix)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (op_is_div && b_zero) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (run_last || mul_done_early) begin
          state_d = S_FIX;
        end
      end
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    if (state_q != S_IDLE) begin
      busy = 1'b1;
    end
    if (state_q == S_DONE) begin
      done = 1'b1;
    end
  end

  // Datapath, counter and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_div_q   <= 1'b0;
      quo_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      rem_q      <= '0;
      lo_q       <= '0;
      cnt_q      <= '0;
      div_zero_q <= 1'b0;
      hi_res_q   <= '0;
      lo_res_q   <= '0;
    end else begin
      if (accept) begin
        op_div_q   <= op_is_div;
        quo_neg_q  <= a_neg ^ b_neg;
        rem_neg_q  <= a_neg;
        a_q        <= a_abs;
        b_q        <= b_abs;
        rem_q      <= '0;
        lo_q       <= op_is_div ? a_abs : '0;
        cnt_q      <= CNT_W'(WIDTH);
        div_zero_q <= op_is_div && b_zero;
      end else if (state_q == S_RUN) begin
        cnt_q <= cnt_q - CNT_W'(1);
        if (op_div_q) begin
          rem_q <= div_ge ? WIDTH'(div_trial - {1'b0, b_q}) : div_trial[WIDTH-1:0];
          lo_q  <= {lo_q[WIDTH-2:0], div_ge};
        end else begin
          rem_q <= mul_sum[WIDTH:1];
          lo_q  <= {mul_sum[0], lo_q[WIDTH-1:1]};
          b_q   <= b_q >> 1;
        end
      end else if (state_q == S_FIX) begin
        hi_res_q <= op_div_q ? rem_fix : prod_fix[W2-1:WIDTH];
        lo_res_q <= op_div_q ? quo_fix : prod_fix[WIDTH-1:0];
      end
    end
  end

  assign div_zero = div_zero_q;
  assign hi_out   = hi_res_q;
  assign lo_out   = lo_res_q;

endmodule
